keycode_tracker: RTL

//  Turns the raw USB HID keycode word from the NIOS keycode PIO into debounced per-action key state.

---
 rtl/keycode_tracker.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/keycode_tracker.sv
// keycode_tracker: debounced per-action key state from the raw HID keycode word, with
// frame-aligned snapshots taken on the rising edge of the asynchronous VGA vsync.
module keycode_tracker #(
  parameter int unsigned                 NUM_KEYS      = 2,
  parameter int unsigned                 NUM_ACTIONS   = 4,
  parameter logic [8*NUM_ACTIONS-1:0]    ACTION_CODES  = {8'h07, 8'h16, 8'h04, 8'h1A},
  parameter int unsigned                 STABLE_CYCLES = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [8*NUM_KEYS-1:0]  keycode,
  input  logic                   frame_clk,
  output logic [NUM_ACTIONS-1:0] held,
  output logic [NUM_ACTIONS-1:0] press_pulse,
  output logic [NUM_ACTIONS-1:0] release_pulse,
  output logic                   frame_tick,
  output logic [NUM_ACTIONS-1:0] frame_held,
  output logic [NUM_ACTIONS-1:0] frame_press,
  output logic                   rollover_err,
  output logic [7:0]             last_code
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [7:0] CodeNone     = 8'h00;
  localparam logic [7:0] CodeRollover = 8'h01;

  // Input register and decode state
  logic [8*NUM_KEYS-1:0]  kc_q;
  logic [NUM_ACTIONS-1:0] raw, raw_eff, raw_hold_q;
  logic                   any_err;

  // Debounce state
  logic [NUM_ACTIONS-1:0]           held_q, held_d;
  logic [NUM_ACTIONS-1:0]           press_q, press_d;
  logic [NUM_ACTIONS-1:0]           release_q, release_d;
  logic [NUM_ACTIONS-1:0][CntW-1:0] cnt_q, cnt_d;

  // Frame path state
  logic                   fs1_q, fs2_q, fs3_q, tick_q;
  logic [NUM_ACTIONS-1:0] press_acc_q, frame_held_q, frame_press_q;

  // Misc registered outputs
  logic       rollover_q;
  logic [7:0] last_code_q;

  // Capture the raw keycode word every cycle
  always_ff @(posedge Clk) begin
    if (Reset) begin
      kc_q <= '0;
    end else begin
      kc_q <= keycode;
    end
  end

  // Decode slots into per-action raw state; duplicates in several slots collapse to one press
  always_comb begin
    logic [7:0] slot;
    raw     = '0;
    any_err = 1'b0;
    slot    = '0;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      slot = kc_q[8*i +: 8];
      if (slot == CodeRollover) begin
        any_err = 1'b1;
      end
      for (int a = 0; a < int'(NUM_ACTIONS); a++) begin
        if ((slot != CodeNone) && (slot == ACTION_CODES[8*a +: 8])) begin
          raw[a] = 1'b1;
        end
      end
    end
    // On ErrorRollOver the slot contents are meaningless, so freeze the last good view
    raw_eff = any_err ? raw_hold_q : raw;
  end

  // Remember the last error-free decode for use while rollover is reported
  always_ff @(posedge Clk) begin
    if (Reset) begin
      raw_hold_q <= '0;
    end else if (!any_err) begin
      raw_hold_q <= raw;
    end
  end

  // Per-action debounce: held flips only after STABLE_CYCLES consecutive disagreeing samples
  always_comb begin
    held_d    = held_q;
    press_d   = '0;
    release_d = '0;
    cnt_d     = '0;
    for (int a = 0; a < int'(NUM_ACTIONS); a++) begin
      if (raw_eff[a] != held_q[a]) begin
        if (cnt_q[a] == CntLast) begin
          held_d[a]    = raw_eff[a];
          press_d[a]   = raw_eff[a];
          release_d[a] = ~raw_eff[a];
        end else begin
          cnt_d[a] = cnt_q[a] + CntW'(1);
        end
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      held_q    <= '0;
      press_q   <= '0;
      release_q <= '0;
      cnt_q     <= '0;
    end else begin
      held_q    <= held_d;
      press_q   <= press_d;
      release_q <= release_d;
      cnt_q     <= cnt_d;
    end
  end

  // Synchronise vsync, detect its rising edge and register the tick
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fs1_q  <= 1'b0;
      fs2_q  <= 1'b0;
      fs3_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      fs1_q  <= frame_clk;
      fs2_q  <= fs1_q;
      fs3_q  <= fs2_q;
      tick_q <= fs2_q & ~fs3_q;
    end
  end

  // Accumulate presses between ticks and snapshot on each tick
  always_ff @(posedge Clk) begin
    if (Reset) begin
      press_acc_q   <= '0;
      frame_held_q  <= '0;
      frame_press_q <= '0;
    end else if (tick_q) begin
      // A press pulse coincident with the tick belongs to the frame being closed
      frame_press_q <= press_acc_q | press_q;
      frame_held_q  <= held_q;
      press_acc_q   <= '0;
    end else begin
      press_acc_q <= press_acc_q | press_q;
    end
  end

  // Rollover flag and last valid slot-0 code
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rollover_q  <= 1'b0;
      last_code_q <= '0;
    end else begin
      rollover_q <= any_err;
      if ((kc_q[7:0] != CodeNone) && (kc_q[7:0] != CodeRollover)) begin
        last_code_q <= kc_q[7:0];
      end
    end
  end

  assign held          = held_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign frame_tick    = tick_q;
  assign frame_held    = frame_held_q;
  assign frame_press   = frame_press_q;
  assign rollover_err  = rollover_q;
  assign last_code     = last_code_q;

endmodule
